// File: rtl/memprog_pkg.sv
// Shared definitions for the program-memory fetch block.
//   - opcode constants (only JMP and HALT are acted on by the fetcher)
//   - fetch FSM state encoding
//   - width helpers: instruction word is {op[2:0], dest[N], src1[N], src2[N]}
package memprog_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  function automatic int iw_of(input int n);
    return 3 * n + 3;
  endfunction

  function automatic int aw_of(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/instr_ram.sv
// Program storage: DEPTH words of IW bits, synchronous write, combinational
// read. Deliberately has no reset so the program survives a fetch reset.
// Ports:
//   clk          write clock
//   we/wadr/wdata write strobe, address, data (out-of-range addresses dropped)
//   radr/rdata   asynchronous read port
module instr_ram #(
  parameter int IW    = 27,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] radr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(wadr) < 32'(DEPTH))) mem[wadr] <= wdata;
  end

  assign rdata = mem[radr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a program into instr_ram while not running,
// then on a run pulse streams words to a decoder over a valid/ready slot.
// JMP and HALT are consumed here and never presented downstream.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   load_en/load_adr/load_data       program write (ignored while running)
//   run                              start pulse (pc restarts at 0)
//   instr/instr_valid/instr_ready    output slot to decoder
//   pc                               address of the next word to fetch
//   busy, halted                     state flags (RUN, HALTED)
module instr_fetch
  import memprog_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int DEPTH = 8,
  localparam int IW    = iw_of(N),
  localparam int AW    = aw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_adr,
  input  logic [IW-1:0] load_data,
  input  logic          run,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  state_t        state, state_n;
  logic [AW-1:0] pc_n, pc_inc, jmp_raw, jmp_tgt;
  logic [IW-1:0] instr_n, rdata;
  logic          valid_n, we, slot_free;
  logic [2:0]    op;

  // Writes are allowed in the same edge as run, so the first fetch sees them.
  assign we = load_en && (state != S_RUN);

  instr_ram #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .wadr  (load_adr),
    .wdata (load_data),
    .radr  (pc),
    .rdata (rdata)
  );

  assign op        = rdata[IW-1 -: 3];
  assign slot_free = !instr_valid || instr_ready;
  assign pc_inc    = (pc == AW'(DEPTH - 1)) ? '0 : pc + 1'b1;

  // JMP target is dest truncated to AW bits, then folded into [0, DEPTH).
  // AW bits span less than 2*DEPTH, so one subtraction is enough.
  assign jmp_raw = rdata[2*N +: AW];
  assign jmp_tgt = (32'(jmp_raw) >= 32'(DEPTH)) ? jmp_raw - AW'(DEPTH) : jmp_raw;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    valid_n = instr_valid;
    if (instr_valid && instr_ready) valid_n = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (run) begin
          state_n = S_RUN;
          pc_n    = '0;
        end
      end
      S_RUN: begin
        if (slot_free) begin
          case (op)
            OP_JMP:  pc_n    = jmp_tgt;   // bubble: slot left empty
            OP_HALT: state_n = S_HALTED;  // pc parks on the HALT word
            default: begin
              instr_n = rdata;
              valid_n = 1'b1;
              pc_n    = pc_inc;
            end
          endcase
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
    end
  end

  assign busy   = (state == S_RUN);
  assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (N=8, DEPTH=8): straight-line program,
// back-pressure, load in RUN/HALTED, reset mid-run, JMP loops and pc wrap.
module tb_instr_fetch;
  import memprog_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 3 * N + 3;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_adr = '0;
  logic [IW-1:0] load_data = '0;
  logic          run = 1'b0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] pc;
  logic          busy, halted;

  int n_chk = 0;
  int n_fail = 0;

  instr_fetch #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_adr    (load_adr),
    .load_data   (load_data),
    .run         (run),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input int d, input int s1, input int s2);
    return {op, N'(d), N'(s1), N'(s2)};
  endfunction

  task automatic load(input int a, input logic [IW-1:0] d);
    load_en = 1'b1; load_adr = AW'(a); load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [IW-1:0] w, input int p);
    chk({tag, ".valid"}, 64'(instr_valid), 64'd1);
    chk({tag, ".instr"}, 64'(instr), 64'(w));
    chk({tag, ".pc"}, 64'(pc), 64'(p));
  endtask

  logic [IW-1:0] w0, w1, w2, wh, wn, wj;

  initial begin
    w0 = mk(OP_MOV, 0, 5, 0);
    w1 = mk(OP_MOV, 1, 7, 0);
    w2 = mk(OP_ADD, 2, 0, 1);
    wh = mk(OP_HALT, 0, 0, 0);
    wn = mk(OP_ADD, 3, 4, 5);

    // reset state
    tick(); tick();
    chk("rst.valid", 64'(instr_valid), 64'd0);
    chk("rst.pc", 64'(pc), 64'd0);
    chk("rst.instr", 64'(instr), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.halted", 64'(halted), 64'd0);
    rst_n = 1'b1;

    // straight-line program, decoder always ready
    load(0, w0); load(1, w1); load(2, w2); load(3, wh);
    instr_ready = 1'b1;
    pulse_run();
    chk("run.busy", 64'(busy), 64'd1);
    chk("run.valid0", 64'(instr_valid), 64'd0);
    tick(); chk_word("p1.w0", w0, 1);
    tick(); chk_word("p1.w1", w1, 2);
    tick(); chk_word("p1.w2", w2, 3);
    tick();
    chk("p1.halted", 64'(halted), 64'd1);
    chk("p1.busy", 64'(busy), 64'd0);
    chk("p1.pc", 64'(pc), 64'd3);
    chk("p1.valid", 64'(instr_valid), 64'd0);

    // back-pressure; load attempt while running must be ignored
    instr_ready = 1'b0;
    pulse_run();
    chk("bp.pc0", 64'(pc), 64'd0);
    tick(); chk_word("bp.first", w0, 1);
    load_en = 1'b1; load_adr = 3'd1; load_data = mk(OP_ADD, 9, 9, 9);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_word($sformatf("bp.hold%0d", i), w0, 1);
    end
    load_en = 1'b0;
    instr_ready = 1'b1;
    tick(); chk_word("bp.w1", w1, 2);
    tick(); chk_word("bp.w2", w2, 3);
    tick(); chk("bp.halted", 64'(halted), 64'd1);

    // load together with run from HALTED: new word is fetched first
    load_en = 1'b1; load_adr = 3'd0; load_data = wn; run = 1'b1;
    tick();
    load_en = 1'b0; run = 1'b0;
    tick(); chk_word("lr.new", wn, 1);
    tick(); chk_word("lr.w1", w1, 2);
    tick(); tick(); chk("lr.halted", 64'(halted), 64'd1);
    load(0, w0);

    // reset mid-run with a pending word
    instr_ready = 1'b0;
    pulse_run();
    tick(); chk_word("mr.pend", w0, 1);
    rst_n = 1'b0;
    #1;
    chk("mr.valid", 64'(instr_valid), 64'd0);
    chk("mr.pc", 64'(pc), 64'd0);
    chk("mr.busy", 64'(busy), 64'd0);
    chk("mr.halted", 64'(halted), 64'd0);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    pulse_run();
    tick(); chk_word("mr.rerun", w0, 1);
    tick(); tick(); tick(); chk("mr.halted2", 64'(halted), 64'd1);

    // JMP back to 0 at address 2: endless loop with bubble
    load(2, mk(OP_JMP, 0, 0, 0));
    pulse_run();
    for (int k = 0; k < 2; k++) begin
      tick(); chk_word($sformatf("j%0d.w0", k), w0, 1);
      tick(); chk_word($sformatf("j%0d.w1", k), w1, 2);
      tick();
      chk($sformatf("j%0d.bubble", k), 64'(instr_valid), 64'd0);
      chk($sformatf("j%0d.pc", k), 64'(pc), 64'd0);
      chk($sformatf("j%0d.busy", k), 64'(busy), 64'd1);
      chk($sformatf("j%0d.halted", k), 64'(halted), 64'd0);
    end

    // JMP target 13 folds to 5, where a HALT sits
    rst_n = 1'b0; #1; rst_n = 1'b1;
    wj = mk(OP_JMP, 13, 0, 0);
    load(2, wj); load(5, wh);
    pulse_run();
    tick(); tick(); tick();
    chk("jf.pc", 64'(pc), 64'd5);
    chk("jf.valid", 64'(instr_valid), 64'd0);
    tick();
    chk("jf.halted", 64'(halted), 64'd1);
    chk("jf.pcH", 64'(pc), 64'd5);

    // no HALT: pc wraps 7 -> 0
    for (int i = 0; i < DEPTH; i++) load(i, mk(OP_MOV, i, i + 1, 0));
    pulse_run();
    for (int i = 0; i < DEPTH; i++) begin
      tick(); chk_word($sformatf("wr.m%0d", i), mk(OP_MOV, i, i + 1, 0), (i + 1) % DEPTH);
    end
    tick(); chk_word("wr.again", mk(OP_MOV, 0, 1, 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
